// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the CPU data port and a video fetch requester.
// Video wins by default; a starvation counter forces a CPU win after MAX_WAIT losses.
module mem_arbiter #(
   parameter int ADDR_W   = 32,
   parameter int DATA_W   = 32,
   parameter int MAX_WAIT = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_gnt,
   output logic              vid_valid,
   output logic [DATA_W-1:0] vid_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {TAG_NONE, TAG_CPU, TAG_VID} tag_t;

   localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

   tag_t       rd_tag_reg, rd_tag_next;
   logic [3:0] cpu_wait_reg, cpu_wait_next;
   logic       cpu_elig;
   logic       cpu_win;
   logic       vid_win;

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_tag_reg   <= TAG_NONE;
         cpu_wait_reg <= 4'd0;
      end else begin
         rd_tag_reg   <= rd_tag_next;
         cpu_wait_reg <= cpu_wait_next;
      end
   end

   always_comb begin
      cpu_elig      = cpu_req && (rd_tag_reg != TAG_CPU);
      cpu_win       = !reset && cpu_elig && (!vid_req || (cpu_wait_reg == WAIT_MAX));
      vid_win       = !reset && vid_req && !cpu_win;

      rd_tag_next   = TAG_NONE;
      if (cpu_win && !cpu_we)
         rd_tag_next = TAG_CPU;
      else if (vid_win)
         rd_tag_next = TAG_VID;

      // A returning CPU read leaves the counter alone; it was cleared on the win.
      cpu_wait_next = cpu_wait_reg;
      if (!cpu_req || cpu_win)
         cpu_wait_next = 4'd0;
      else if (cpu_elig && vid_win && (cpu_wait_reg < WAIT_MAX))
         cpu_wait_next = cpu_wait_reg + 4'd1;

      mem_addr  = vid_win ? vid_addr : cpu_addr;
      mem_we    = cpu_win && cpu_we;
      mem_wdata = cpu_wdata;
      vid_gnt   = vid_win;
      vid_valid = !reset && (rd_tag_reg == TAG_VID);
      vid_rdata = mem_rdata;
      cpu_rdata = mem_rdata;

      // During reset an in-flight CPU return is discarded, so the CPU stays held.
      if (reset)
         cpu_stall = cpu_req;
      else
         cpu_stall = cpu_req && !(cpu_win && cpu_we) && (rd_tag_reg != TAG_CPU);
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_mem_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int MW = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          cpu_req, cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata, cpu_rdata;
   logic          cpu_stall;
   logic          vid_req;
   logic [AW-1:0] vid_addr;
   logic          vid_gnt, vid_valid;
   logic [DW-1:0] vid_rdata;
   logic [AW-1:0] mem_addr;
   logic          mem_we;
   logic [DW-1:0] mem_wdata, mem_rdata;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
      .vid_valid(vid_valid), .vid_rdata(vid_rdata),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Synchronous-read RAM attached to the arbiter
   logic [DW-1:0] ram [0:255];
   always @(posedge clk) begin
      if (mem_we) ram[mem_addr[9:2]] <= mem_wdata;
      mem_rdata <= ram[mem_addr[9:2]];
   end

   // Reference model state
   logic [DW-1:0] ref_mem [0:255];
   int            owner, owner_n;       // 0 none, 1 cpu, 2 video: whose data returns now
   int            losses, losses_n;     // consecutive arbitration losses of the CPU
   logic [DW-1:0] ret_data, ret_n;
   logic          e_stall, e_we, e_gnt, e_valid, m_cpu_win, m_vid_win, cpu_done;
   logic [AW-1:0] e_addr;
   int            tests = 0;
   int            fails = 0;
   logic          cpu_pend, vid_pend;

   function automatic logic [31:0] pat(int i);
      return (32'(i) * 32'h01010101) ^ 32'hA5A50000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Compute expected outputs from the arbitration rules, then compare the DUT.
   task automatic eval();
      logic cpu_can;
      #1;
      if (reset) begin
         m_cpu_win = 1'b0;
         m_vid_win = 1'b0;
         cpu_done  = 1'b0;
         e_we      = 1'b0;
         e_gnt     = 1'b0;
         e_valid   = 1'b0;
         e_addr    = cpu_addr;
         e_stall   = cpu_req;
         owner_n   = 0;
         losses_n  = 0;
         ret_n     = ret_data;
      end else begin
         cpu_can   = cpu_req && (owner != 1);
         m_cpu_win = cpu_can && (!vid_req || losses >= MW);
         m_vid_win = vid_req && !m_cpu_win;
         e_we      = m_cpu_win && cpu_we;
         e_gnt     = m_vid_win;
         e_valid   = (owner == 2);
         e_addr    = m_vid_win ? vid_addr : cpu_addr;
         cpu_done  = (cpu_req && owner == 1) || e_we;
         e_stall   = cpu_req && !cpu_done;
         owner_n   = 0;
         ret_n     = ret_data;
         if (m_cpu_win && !cpu_we) begin
            owner_n = 1;
            ret_n   = ref_mem[cpu_addr[9:2]];
         end else if (m_vid_win) begin
            owner_n = 2;
            ret_n   = ref_mem[vid_addr[9:2]];
         end
         if (!cpu_req || m_cpu_win)  losses_n = 0;
         else if (cpu_can && m_vid_win) losses_n = (losses + 1 > MW) ? MW : losses + 1;
         else                         losses_n = losses;
      end
      chk("m_stall", cpu_stall, e_stall);
      chk("m_we", mem_we, e_we);
      chk("m_gnt", vid_gnt, e_gnt);
      chk("m_valid", vid_valid, e_valid);
      chk("m_addr", mem_addr, e_addr);
      chk("m_wdata", mem_wdata, cpu_wdata);
      if (!reset && owner == 1) chk("m_cpu_rdata", cpu_rdata, ret_data);
      if (!reset && owner == 2) chk("m_vid_rdata", vid_rdata, ret_data);
   endtask

   task automatic advance();
      @(posedge clk);
      if (e_we) ref_mem[cpu_addr[9:2]] = cpu_wdata;
      owner    = owner_n;
      losses   = losses_n;
      ret_data = ret_n;
      @(negedge clk);
   endtask

   task automatic contention(input logic [31:0] addr, input int word);
      vid_req = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = addr;
      for (int c = 0; c < 5; c++) begin
         vid_addr = 32'h200 + 32'(4 * c);
         eval();
         if (c < 3) begin
            chk("cont_vid_gnt", vid_gnt, 1);
            chk("cont_stall", cpu_stall, 1);
         end else if (c == 3) begin
            chk("cont_cpu_gnt", vid_gnt, 0);
            chk("cont_cpu_addr", mem_addr, addr);
            chk("cont_cpu_stall", cpu_stall, 1);
         end else begin
            chk("cont_ret_stall", cpu_stall, 0);
            chk("cont_ret_data", cpu_rdata, pat(word));
            chk("cont_ret_gnt", vid_gnt, 1);
         end
         advance();
      end
      cpu_req = 1'b0; vid_req = 1'b0;
      eval(); advance();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         ram[i]     = pat(i);
         ref_mem[i] = pat(i);
      end
      ram[8] = 32'h12345678; ref_mem[8] = 32'h12345678;
      owner = 0; losses = 0; ret_data = '0;
      reset = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h40; cpu_wdata = '0;
      vid_req = 1'b1; vid_addr = 32'h80;
      @(negedge clk);

      // Reset held two cycles with both requesters active
      repeat (2) begin
         eval();
         chk("rst_stall", cpu_stall, 1);
         chk("rst_gnt", vid_gnt, 0);
         chk("rst_we", mem_we, 0);
         advance();
      end
      reset = 1'b0; cpu_req = 1'b0; vid_req = 1'b0;
      eval();
      chk("post_rst_valid", vid_valid, 0);
      chk("post_rst_stall", cpu_stall, 0);
      advance();

      // Uncontended CPU write
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
      eval();
      chk("wr_we", mem_we, 1);
      chk("wr_addr", mem_addr, 32'h10);
      chk("wr_stall", cpu_stall, 0);
      chk("wr_wdata", mem_wdata, 32'hDEADBEEF);
      advance();

      // Uncontended CPU read, then a write that must not be blocked by a re-issue
      cpu_we = 1'b0; cpu_addr = 32'h20;
      eval();
      chk("rd_stall0", cpu_stall, 1);
      chk("rd_addr", mem_addr, 32'h20);
      chk("rd_we", mem_we, 0);
      advance();
      eval();
      chk("rd_stall1", cpu_stall, 0);
      chk("rd_data", cpu_rdata, 32'h12345678);
      advance();
      cpu_we = 1'b1; cpu_addr = 32'h30; cpu_wdata = 32'h55;
      eval();
      chk("rd_noreissue_we", mem_we, 1);
      chk("rd_noreissue_stall", cpu_stall, 0);
      advance();
      cpu_req = 1'b0;

      // Video streaming, one grant per cycle
      for (int i = 0; i < 8; i++) begin
         vid_req = 1'b1; vid_addr = 32'h100 + 32'(4 * i);
         eval();
         chk("stream_gnt", vid_gnt, 1);
         if (i > 0) begin
            chk("stream_valid", vid_valid, 1);
            chk("stream_data", vid_rdata, pat(64 + i - 1));
         end
         advance();
      end
      vid_req = 1'b0;
      eval();
      chk("stream_last_valid", vid_valid, 1);
      chk("stream_last_data", vid_rdata, pat(71));
      advance();

      contention(32'h24, 9);

      // Reset right after a video grant discards the return
      vid_req = 1'b1; vid_addr = 32'h300;
      eval();
      chk("rg_gnt", vid_gnt, 1);
      advance();
      reset = 1'b1; vid_req = 1'b0;
      eval();
      chk("rg_valid_rst", vid_valid, 0);
      advance();
      reset = 1'b0;
      eval();
      chk("rg_valid_after", vid_valid, 0);
      advance();
      contention(32'h28, 10);

      // Randomized traffic
      cpu_pend = 1'b0; vid_pend = 1'b0;
      for (int n = 0; n < 4000; n++) begin
         reset = ($urandom_range(0, 59) == 0);
         if (!cpu_pend && $urandom_range(0, 2) == 0) begin
            cpu_pend  = 1'b1;
            cpu_we    = 1'($urandom_range(0, 1));
            cpu_addr  = $urandom_range(0, 63) << 2;
            cpu_wdata = $urandom;
         end
         if (!vid_pend && $urandom_range(0, 1) == 1) begin
            vid_pend = 1'b1;
            vid_addr = $urandom_range(0, 63) << 2;
         end
         cpu_req = cpu_pend;
         vid_req = vid_pend;
         eval();
         advance();
         if (cpu_done)  cpu_pend = 1'b0;
         if (m_vid_win) vid_pend = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
